dot_seq_ctrl: RTL and testbench
===============================

# dot_seq_ctrl

Sequencer that computes a signed dot product of two vectors held in operand memory by driving the shared ALU one operation at a time. Each element is fetched, multiplied (op MUL) and accumulated (op ADD). The block exposes a start/busy/done command interface to the core control unit. It owns the ALU's `op_code` and operand buses while busy.

## Interface

**Parameters**
- `DATA_W`, 32: operand, ALU and result width.
- `ADDR_W`, 8: operand memory address width.
- `LEN_W`, 8: vector length field width.

**Ports**
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: command strobe; sampled only in IDLE.
- `vec_len`, input, LEN_W: element count N, sampled with `start`.
- `base_a`, input, ADDR_W: base address of vector A, sampled with `start`.
- `base_b`, input, ADDR_W: base address of vector B, sampled with `start`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `result`, output, DATA_W: final accumulator value, held until the next accepted `start`.
- `mem_rd_en`, output, 1: operand read strobe.
- `mem_addr_a`, output, ADDR_W: read address for A.
- `mem_addr_b`, output, ADDR_W: read address for B.
- `mem_data_a`, input, DATA_W: A read data, valid exactly one cycle after `mem_rd_en`.
- `mem_data_b`, input, DATA_W: B read data, same timing as `mem_data_a`.
- `alu_op`, output, 3: ALU op code (ADD=3'b000, MUL=3'b001).
- `alu_in1`, output, DATA_W: ALU operand 1.
- `alu_in2`, output, DATA_W: ALU operand 2.
- `alu_out`, input, DATA_W: combinational ALU result, lower DATA_W bits.

## Operation

**States:** IDLE, FETCH, MUL, ACC, DONE.

- **IDLE**
  - `start=1` latches `vec_len`, `base_a` and `base_b`, clears the index and accumulator, and clears `result`.
  - If `vec_len=0`, go to DONE; otherwise go to FETCH.
- **FETCH**
  - Drive `mem_rd_en=1`, `mem_addr_a = base_a + idx` and `mem_addr_b = base_b + idx`.
  - Addition is modulo 2^ADDR_W, so addresses wrap.
  - Go to MUL.
- **MUL**
  - Drive `alu_op=MUL`, `alu_in1=mem_data_a`, `alu_in2=mem_data_b`.
  - Latch `alu_out` into the product register.
  - Go to ACC.
- **ACC**
  - Drive `alu_op=ADD`, `alu_in1=acc`, `alu_in2=product`.
  - Latch `alu_out` into `acc` and increment `idx`.
  - If `idx+1 == N`, go to DONE; else go to FETCH.
- **DONE**
  - `done=1` and `result=acc` (registered); go to IDLE.

**Arithmetic and ALU bus rules**
- All arithmetic is two's-complement at DATA_W bits. Products and sums are truncated by the ALU (wrap-around); there is no saturation and no overflow flag.
- Outside MUL and ACC: `alu_op=3'b000` and `alu_in1=alu_in2=0`.
- `mem_rd_en=0` and both addresses are 0 outside FETCH.

**Command handling**
- `start` while busy is ignored; no queuing.
- The latched command fields are stable for the whole operation, so input changes after acceptance have no effect.

**Reset**
- Asserting `rst_n=0` at any time, including mid-operation, forces IDLE immediately.
- Reset values: `busy=0`, `done=0`, `result=0`, `mem_rd_en=0`, addresses 0, `alu_op=0`, `alu_in1=alu_in2=0`.
- Internal `acc`, `product` and `idx` reset to 0.
- A partial result is discarded and `done` is not pulsed.

## Timing

- Cycle 0 is the cycle in which `start=1` is sampled in IDLE.
- For N>0:
  - Element k occupies FETCH at cycle 3k+1, MUL at 3k+2 and ACC at 3k+3.
  - DONE is at cycle 3N+1, so `done`/`result` latency is 3N+1 cycles.
- For N=0: DONE at cycle 1, `result=0`.
- `busy` rises in cycle 1 and falls in cycle 3N+2, when the state is back in IDLE.
- A new `start` is accepted no earlier than cycle 3N+2, giving back-to-back throughput of one command per 3N+2 cycles.
- `done` is high for exactly one cycle. `result` updates in the same cycle `done` rises and holds until the next accepted `start` clears it.
- ALU ops are combinational and produce exactly one ALU operation per MUL/ACC cycle. The ALU bus is never driven with MUL or ADD in any other state.

## Test plan

- **Basic dot product:** A=[1,2,3] at 0x10, B=[4,5,6] at 0x20, N=3.
  - Reads at 0x10/0x20, 0x11/0x21, 0x12/0x22.
  - `done` in cycle 10 with `result=32`; `busy` high cycles 1–10.
- **Signed operands:** A=[-2,3], B=[7,-4], N=2 → `result=0xFFFFFFE6` (-26), `done` in cycle 7.
- **Zero length:** N=0 → no `mem_rd_en`, no MUL/ADD on the ALU bus, `done` in cycle 1, `result=0`.
- **Wrap-around:** N=3, `base_a=0xFE`, `base_b=0xFF`, A=[0x10000, 1, 0], B=[0x10000, 0x7FFFFFFF, 5].
  - Addresses read: A at 0xFE, 0xFF, 0x00; B at 0xFF, 0x00, 0x01.
  - First product truncates to 0, so `result=0x7FFFFFFF`.
- **Busy rejection:** pulse `start` with different fields at cycles 2 and 5 during an N=3 run → ignored; the original result and timing are unchanged.
- **Reset mid-operation:** drop `rst_n` at cycle 5 of an N=3 run.
  - All outputs go to 0 asynchronously and `done` never pulses.
  - A new `start` after reset release completes normally with the correct result.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// Signed dot-product sequencer: walks two operand vectors, issuing one MUL then
// one ADD on the shared ALU per element, with a start/busy/done command port.
module dot_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_data_a,
    input  logic [DATA_W-1:0] mem_data_b,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            idx      <= '0;
            acc      <= '0;
            product  <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= vec_len;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        idx      <= '0;
                        acc      <= '0;
                        result   <= '0;
                        state    <= (vec_len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state <= S_MUL;
                S_MUL: begin
                    product <= alu_out;
                    state   <= S_ACC;
                end
                S_ACC: begin
                    acc <= alu_out;
                    idx <= idx + LEN_W'(1);
                    // Final sum is captured here so result is already valid while done is high.
                    if (idx == len_q - LEN_W'(1)) begin
                        result <= alu_out;
                        state  <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mem_rd_en  = 1'b0;
        mem_addr_a = '0;
        mem_addr_b = '0;
        alu_op     = OP_ADD;
        alu_in1    = '0;
        alu_in2    = '0;
        case (state)
            S_FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr_a = base_a_q + ADDR_W'(idx);
                mem_addr_b = base_b_q + ADDR_W'(idx);
            end
            S_MUL: begin
                alu_op  = OP_MUL;
                alu_in1 = mem_data_a;
                alu_in2 = mem_data_b;
            end
            S_ACC: begin
                alu_op  = OP_ADD;
                alu_in1 = acc;
                alu_in2 = product;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl with a registered operand memory and a combinational ALU.
module tb_dot_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic [7:0]  base_a;
    logic [7:0]  base_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        mem_rd_en;
    logic [7:0]  mem_addr_a;
    logic [7:0]  mem_addr_b;
    logic [31:0] mem_data_a;
    logic [31:0] mem_data_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dot_seq_ctrl #(.DATA_W(32), .ADDR_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_len    (vec_len),
        .base_a     (base_a),
        .base_b     (base_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mem_rd_en  (mem_rd_en),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_data_a (mem_data_a),
        .mem_data_b (mem_data_b),
        .alu_op     (alu_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out)
    );

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data_a <= mem_a[mem_addr_a];
            mem_data_b <= mem_b[mem_addr_b];
        end
    end

    assign alu_out = (alu_op == 3'b001) ? alu_in1 * alu_in2 : alu_in1 + alu_in2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " result"}, result, 32'd0);
        chk({tag, " rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, " addr_a"}, 32'(mem_addr_a), 32'd0);
        chk({tag, " addr_b"}, 32'(mem_addr_b), 32'd0);
        chk({tag, " alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, " alu_in1"}, alu_in1, 32'd0);
        chk({tag, " alu_in2"}, alu_in2, 32'd0);
    endtask

    // Cycle c is observed at the negedge after c rising edges following the start cycle.
    task automatic run_op(input string name, input int n, input logic [7:0] ba,
                          input logic [7:0] bb, input logic [31:0] exp_res, input bit inject);
        logic [31:0] racc, prod, e_i1, e_i2;
        logic [7:0]  ea, eb;
        logic        e_rd;
        logic [2:0]  e_op;
        int          k, ph;
        racc = '0;
        prod = '0;
        @(negedge clk);
        chk($sformatf("%s c0 busy", name), 32'(busy), 32'd0);
        start   = 1'b1;
        vec_len = 8'(n);
        base_a  = ba;
        base_b  = bb;
        for (int c = 1; c <= 3 * n + 2; c++) begin
            @(negedge clk);
            e_rd = 1'b0; ea = '0; eb = '0; e_op = 3'b000; e_i1 = '0; e_i2 = '0;
            if (c <= 3 * n) begin
                k  = (c - 1) / 3;
                ph = (c - 1) % 3;
                ea = ba + 8'(k);
                eb = bb + 8'(k);
                if (ph == 0) begin
                    e_rd = 1'b1;
                end else if (ph == 1) begin
                    e_op = 3'b001;
                    e_i1 = mem_a[ea];
                    e_i2 = mem_b[eb];
                    prod = e_i1 * e_i2;
                    ea = '0; eb = '0;
                end else begin
                    e_i1 = racc;
                    e_i2 = prod;
                    racc = racc + prod;
                    ea = '0; eb = '0;
                end
            end
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= 3 * n + 1));
            chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == 3 * n + 1));
            chk($sformatf("%s c%0d rd_en", name, c), 32'(mem_rd_en), 32'(e_rd));
            chk($sformatf("%s c%0d addr_a", name, c), 32'(mem_addr_a), 32'(ea));
            chk($sformatf("%s c%0d addr_b", name, c), 32'(mem_addr_b), 32'(eb));
            chk($sformatf("%s c%0d alu_op", name, c), 32'(alu_op), 32'(e_op));
            chk($sformatf("%s c%0d alu_in1", name, c), alu_in1, e_i1);
            chk($sformatf("%s c%0d alu_in2", name, c), alu_in2, e_i2);
            if (c == 1 && n > 0) chk($sformatf("%s c1 result cleared", name), result, 32'd0);
            if (c >= 3 * n + 1) chk($sformatf("%s c%0d result", name, c), result, exp_res);
            start = inject && (c == 2 || c == 5);
            if (start) begin
                vec_len = 8'd1;
                base_a  = 8'h40;
                base_b  = 8'h50;
            end
        end
        @(negedge clk);
        chk({name, " post busy"}, 32'(busy), 32'd0);
        chk({name, " post done"}, 32'(done), 32'd0);
        chk({name, " post result"}, result, exp_res);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h10] = 32'd1; mem_a[8'h11] = 32'd2; mem_a[8'h12] = 32'd3;
        mem_b[8'h20] = 32'd4; mem_b[8'h21] = 32'd5; mem_b[8'h22] = 32'd6;
        mem_a[8'h30] = 32'hFFFF_FFFE; mem_a[8'h31] = 32'd3;
        mem_b[8'h38] = 32'd7;         mem_b[8'h39] = 32'hFFFF_FFFC;
        mem_a[8'hFE] = 32'h0001_0000; mem_a[8'hFF] = 32'd1; mem_a[8'h00] = 32'd0;
        mem_b[8'hFF] = 32'h0001_0000; mem_b[8'h00] = 32'h7FFF_FFFF; mem_b[8'h01] = 32'd5;
        mem_a[8'h40] = 32'd9; mem_b[8'h50] = 32'd9;
        mem_data_a = '0;
        mem_data_b = '0;
        start   = 1'b0;
        vec_len = '0;
        base_a  = '0;
        base_b  = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_op("basic", 3, 8'h10, 8'h20, 32'd32, 1'b0);
        run_op("signed", 2, 8'h30, 8'h38, 32'hFFFF_FFE6, 1'b0);
        run_op("zero_len", 0, 8'h10, 8'h20, 32'd0, 1'b0);
        run_op("wrap", 3, 8'hFE, 8'hFF, 32'h7FFF_FFFF, 1'b0);
        run_op("busy_rej", 3, 8'h10, 8'h20, 32'd32, 1'b1);

        @(negedge clk);
        start = 1'b1; vec_len = 8'd3; base_a = 8'h10; base_b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid pre alu_op", 32'(alu_op), 32'd1);
        chk("rst_mid pre busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid idle%0d done", c), 32'(done), 32'd0);
            chk($sformatf("rst_mid idle%0d busy", c), 32'(busy), 32'd0);
        end
        run_op("after_rst", 3, 8'h10, 8'h20, 32'd32, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
